// File: rtl/spi_slave_6502.sv
// SPI mode-0 target on the 6502 bus: MSB-first byte stream with RX/TX FIFOs.
// Define SPI_SLAVE_6502_IRQ_EN to build the registered interrupt output and CTRL irq_en bit.
module spi_slave_6502 #(
    parameter int unsigned address_width = 16,
    parameter int unsigned data_width    = 8,
    parameter int unsigned BaseAddress   = 'h9230,
    parameter int unsigned FifoDepth     = 8,
    parameter int unsigned FillByte      = 'hFF
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic [address_width-1:0] address_i,
    input  logic [data_width-1:0]    data_i,
    output logic [data_width-1:0]    data_o,
    input  logic                     rd_wr_i,
    input  logic                     spi_sclk_i,
    input  logic                     spi_cs_ni,
    input  logic                     spi_mosi_i,
    output logic                     spi_miso_o,
    output logic                     irq_o
);
    localparam int unsigned AW = $clog2(FifoDepth);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(FifoDepth);
    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] ACTIVE = 1'b1;

    logic [2:0] sclk_sync, cs_sync;
    logic [1:0] mosi_sync;
    logic       sclk_rise, sclk_fall, cs_fall, cs_rise, cs_active;

    logic [0:0] state, state_next;
    logic       frame_start, frame_end, spi_rise, spi_fall;

    logic [2:0]            bitcnt;
    logic [data_width-1:0] rx_shift, tx_shift, rx_byte, tx_load_byte, rd_data;

    logic [data_width-1:0] rx_mem [FifoDepth];
    logic [data_width-1:0] tx_mem [FifoDepth];
    logic [AW-1:0] rx_wr, rx_rd, tx_wr, tx_rd;
    logic [CW-1:0] rx_count, tx_count;
    logic rx_empty, rx_full, tx_empty, tx_full;
    logic rx_overflow, tx_underflow, frame_done;

    logic [address_width-1:0] offset;
    logic       in_range, rd_sel, wr_sel, ctrl_wr;
    logic [2:0] reg_sel;
    logic tx_load, tx_pop, tx_push, rx_pop, rx_push, spi_push;
    logic [7:0] status, ctrl_rd;

    // Two-flop synchronizers plus one history flop for edge detection
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            sclk_sync <= 3'b000;
            cs_sync   <= 3'b111;
            mosi_sync <= 2'b00;
        end else begin
            sclk_sync <= {sclk_sync[1:0], spi_sclk_i};
            cs_sync   <= {cs_sync[1:0], spi_cs_ni};
            mosi_sync <= {mosi_sync[0], spi_mosi_i};
        end
    end

    assign sclk_rise = sclk_sync[1] & ~sclk_sync[2];
    assign sclk_fall = ~sclk_sync[1] & sclk_sync[2];
    assign cs_fall   = ~cs_sync[1] & cs_sync[2];
    assign cs_rise   = cs_sync[1] & ~cs_sync[2];
    assign cs_active = ~cs_sync[1];

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) state <= IDLE;
        else         state <= state_next;
    end

    // CS rise wins over any sclk edge seen in the same cycle
    always_comb begin
        state_next  = state;
        frame_start = 1'b0;
        frame_end   = 1'b0;
        spi_rise    = 1'b0;
        spi_fall    = 1'b0;
        case (state)
            IDLE: begin
                if (cs_fall) begin
                    state_next  = ACTIVE;
                    frame_start = 1'b1;
                end
            end
            ACTIVE: begin
                if (cs_rise) begin
                    state_next = IDLE;
                    frame_end  = 1'b1;
                end else begin
                    spi_rise = sclk_rise;
                    spi_fall = sclk_fall;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign offset   = address_i - address_width'(BaseAddress);
    assign in_range = offset < address_width'(5);
    assign reg_sel  = offset[2:0];
    assign rd_sel   = in_range & ~rd_wr_i;
    assign wr_sel   = in_range & rd_wr_i;
    assign ctrl_wr  = wr_sel & (reg_sel == 3'd3);

    assign rx_empty = (rx_count == '0);
    assign rx_full  = (rx_count == FULL_COUNT);
    assign tx_empty = (tx_count == '0);
    assign tx_full  = (tx_count == FULL_COUNT);

    assign rx_byte      = {rx_shift[data_width-2:0], mosi_sync[1]};
    assign tx_load_byte = tx_empty ? data_width'(FillByte) : tx_mem[tx_rd];
    assign tx_load      = frame_start | (spi_fall & (bitcnt == 3'd0));
    assign tx_pop       = tx_load & ~tx_empty;
    assign tx_push      = wr_sel & (reg_sel == 3'd1) & (~tx_full | tx_pop);
    assign spi_push     = spi_rise & (bitcnt == 3'd7);
    assign rx_pop       = rd_sel & (reg_sel == 3'd0) & ~rx_empty;
    assign rx_push      = spi_push & (~rx_full | rx_pop);

    assign status = {frame_done, cs_active, tx_underflow, rx_overflow,
                     tx_full, tx_empty, rx_full, ~rx_empty};

`ifdef SPI_SLAVE_6502_IRQ_EN
    logic irq_en;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            irq_en <= 1'b0;
            irq_o  <= 1'b0;
        end else begin
            if (ctrl_wr && data_i[7]) irq_en <= 1'b1;
            irq_o <= irq_en & (~rx_empty | rx_overflow | frame_done);
        end
    end

    assign ctrl_rd = {irq_en, 7'b0};
`else
    assign irq_o   = 1'b0;
    assign ctrl_rd = 8'h00;
`endif

    always_comb begin
        rd_data = '0;
        if (rd_sel) begin
            case (reg_sel)
                3'd0:    rd_data = rx_empty ? '0 : rx_mem[rx_rd];
                3'd2:    rd_data = status;
                3'd3:    rd_data = ctrl_rd;
                3'd4:    rd_data = data_width'(rx_count);
                default: rd_data = '0;
            endcase
        end
    end

    // FIFO storage needs no reset; occupancy lives in the counters
    always_ff @(posedge clk_i) begin
        if (rx_push) rx_mem[rx_wr] <= rx_byte;
        if (tx_push) tx_mem[tx_wr] <= data_i;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            data_o       <= '0;
            spi_miso_o   <= 1'b0;
            bitcnt       <= 3'd0;
            rx_shift     <= '0;
            tx_shift     <= '0;
            rx_wr        <= '0;
            rx_rd        <= '0;
            rx_count     <= '0;
            tx_wr        <= '0;
            tx_rd        <= '0;
            tx_count     <= '0;
            rx_overflow  <= 1'b0;
            tx_underflow <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            data_o <= rd_data;

            if (frame_end) begin
                bitcnt     <= 3'd0;
                rx_shift   <= '0;
                spi_miso_o <= 1'b0;
            end else begin
                if (spi_rise) begin
                    rx_shift <= rx_byte;
                    bitcnt   <= bitcnt + 3'd1;
                end
                if (frame_start) bitcnt <= 3'd0;
                if (tx_load) begin
                    tx_shift   <= tx_load_byte;
                    spi_miso_o <= tx_load_byte[data_width-1];
                end else if (spi_fall) begin
                    tx_shift   <= tx_shift << 1;
                    spi_miso_o <= tx_shift[data_width-2];
                end
            end

            // Flush beats any push/pop landing in the same cycle
            if (ctrl_wr && data_i[3]) begin
                rx_wr    <= '0;
                rx_rd    <= '0;
                rx_count <= '0;
            end else begin
                if (rx_push) rx_wr <= rx_wr + AW'(1);
                if (rx_pop)  rx_rd <= rx_rd + AW'(1);
                if (rx_push && !rx_pop)      rx_count <= rx_count + CW'(1);
                else if (!rx_push && rx_pop) rx_count <= rx_count - CW'(1);
            end

            if (ctrl_wr && data_i[4]) begin
                tx_wr    <= '0;
                tx_rd    <= '0;
                tx_count <= '0;
            end else begin
                if (tx_push) tx_wr <= tx_wr + AW'(1);
                if (tx_pop)  tx_rd <= tx_rd + AW'(1);
                if (tx_push && !tx_pop)      tx_count <= tx_count + CW'(1);
                else if (!tx_push && tx_pop) tx_count <= tx_count - CW'(1);
            end

            // Clears beat sets
            if (ctrl_wr && data_i[0])            rx_overflow <= 1'b0;
            else if (spi_push && rx_full && !rx_pop) rx_overflow <= 1'b1;
            if (ctrl_wr && data_i[1])            tx_underflow <= 1'b0;
            else if (tx_load && tx_empty)        tx_underflow <= 1'b1;
            if (ctrl_wr && data_i[2])            frame_done <= 1'b0;
            else if (frame_end)                  frame_done <= 1'b1;
        end
    end
endmodule

// File: tb/tb_spi_slave_6502.sv
// Directed bench for spi_slave_6502: bus register access plus an SPI mode-0 host model.
module tb_spi_slave_6502;
    localparam logic [15:0] BASE = 16'h9230;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] address = 16'h0000;
    logic [7:0]  wdata = 8'h00;
    logic [7:0]  rdata;
    logic        rd_wr = 1'b0;
    logic        sclk = 1'b0;
    logic        cs_n = 1'b1;
    logic        mosi = 1'b0;
    logic        miso;
    logic        irq;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    spi_slave_6502 dut (
        .clk_i      (clk),
        .reset_i    (reset),
        .address_i  (address),
        .data_i     (wdata),
        .data_o     (rdata),
        .rd_wr_i    (rd_wr),
        .spi_sclk_i (sclk),
        .spi_cs_ni  (cs_n),
        .spi_mosi_i (mosi),
        .spi_miso_o (miso),
        .irq_o      (irq)
    );

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        address = a; wdata = d; rd_wr = 1'b1;
        @(negedge clk);
        address = 16'h0000; wdata = 8'h00; rd_wr = 1'b0;
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [7:0] d);
        @(negedge clk);
        address = a; rd_wr = 1'b0;
        @(posedge clk);
        #1 d = rdata;
        @(negedge clk);
        address = 16'h0000;
    endtask

    // sclk = clk/8: MOSI set and MISO sampled while sclk is low
    task automatic spi_bit(input logic b, output logic r);
        mosi = b;
        tick(4);
        r = miso;
        sclk = 1'b1;
        tick(4);
        sclk = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] t, output logic [7:0] r);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            spi_bit(t[i], b);
            r[i] = b;
        end
    endtask

    task automatic cs_begin();
        tick(1);
        cs_n = 1'b0;
        tick(2);
    endtask

    task automatic cs_end();
        tick(4);
        cs_n = 1'b1;
        tick(6);
    endtask

    task automatic test_reset();
        logic [7:0] d;
        reset = 1'b1;
        tick(3);
        vectors++;
        if ({rdata, miso, irq} !== 10'h000) begin
            errors++;
            $display("FAIL reset_outputs: got data_o=%h miso=%b irq=%b expected 00/0/0", rdata, miso, irq);
        end
        reset = 1'b0;
        tick(4);
        bus_read(BASE + 16'd2, d);
        vectors++;
        if (d !== 8'h04) begin errors++; $display("FAIL reset_status: got %h expected 04", d); end
        bus_read(BASE, d);
        vectors++;
        if (d !== 8'h00) begin errors++; $display("FAIL reset_rx_empty_read: got %h expected 00", d); end
        vectors++;
        if (miso !== 1'b0) begin errors++; $display("FAIL reset_miso: got %b expected 0", miso); end
    endtask

    task automatic test_basic_frame();
        logic [7:0] d, r;
        bus_write(BASE + 16'd1, 8'hA5);
        bus_read(BASE + 16'd2, d);
        vectors++;
        if (d !== 8'h00) begin errors++; $display("FAIL basic_status_tx_loaded: got %h expected 00", d); end
        cs_begin();
        spi_byte(8'h3C, r);
        cs_end();
        vectors++;
        if (r !== 8'hA5) begin errors++; $display("FAIL basic_host_rx: got %h expected a5", r); end
        bus_read(BASE + 16'd5, d);
        vectors++;
        if (d !== 8'h00) begin errors++; $display("FAIL basic_out_of_range_hi: got %h expected 00", d); end
        bus_read(BASE - 16'd1, d);
        vectors++;
        if (d !== 8'h00) begin errors++; $display("FAIL basic_out_of_range_lo: got %h expected 00", d); end
        bus_read(BASE + 16'd4, d);
        vectors++;
        if (d !== 8'h01) begin errors++; $display("FAIL basic_rx_count: got %h expected 01", d); end
        bus_read(BASE, d);
        vectors++;
        if (d !== 8'h3C) begin errors++; $display("FAIL basic_rx_pop: got %h expected 3c", d); end
        // Trailing sclk fall reloads from an empty TX FIFO, so underflow is set too
        bus_read(BASE + 16'd2, d);
        vectors++;
        if (d !== 8'hA4) begin errors++; $display("FAIL basic_status_after: got %h expected a4", d); end
        bus_write(BASE + 16'd3, 8'h07);
        bus_read(BASE + 16'd2, d);
        vectors++;
        if (d !== 8'h04) begin errors++; $display("FAIL basic_status_cleared: got %h expected 04", d); end
    endtask

    task automatic test_overflow();
        logic [7:0] d, r;
        cs_begin();
        for (int i = 0; i < 9; i++) begin
            spi_byte(8'h10 + 8'(i), r);
            vectors++;
            if (r !== 8'hFF) begin errors++; $display("FAIL ovf_fill_byte_%0d: got %h expected ff", i, r); end
        end
        tick(4);
        bus_read(BASE + 16'd2, d);
        vectors++;
        if (d !== 8'h77) begin errors++; $display("FAIL ovf_status: got %h expected 77", d); end
        bus_read(BASE + 16'd4, d);
        vectors++;
        if (d !== 8'h08) begin errors++; $display("FAIL ovf_rx_count: got %h expected 08", d); end
        bus_write(BASE + 16'd3, 8'h1B);
        bus_read(BASE + 16'd2, d);
        vectors++;
        if (d !== 8'h44) begin errors++; $display("FAIL ovf_status_flushed: got %h expected 44", d); end
        bus_read(BASE + 16'd4, d);
        vectors++;
        if (d !== 8'h00) begin errors++; $display("FAIL ovf_count_flushed: got %h expected 00", d); end
        cs_end();
        bus_read(BASE + 16'd2, d);
        vectors++;
        if (d !== 8'h84) begin errors++; $display("FAIL ovf_status_frame_done: got %h expected 84", d); end
        bus_write(BASE + 16'd3, 8'h07);
    endtask

    task automatic test_partial_frame();
        logic [7:0] d, r;
        logic b;
        cs_begin();
        for (int i = 0; i < 5; i++) spi_bit(1'(i % 2 == 0), b);
        cs_end();
        bus_read(BASE + 16'd4, d);
        vectors++;
        if (d !== 8'h00) begin errors++; $display("FAIL partial_rx_count: got %h expected 00", d); end
        bus_read(BASE + 16'd2, d);
        vectors++;
        if (d !== 8'hA4) begin errors++; $display("FAIL partial_status: got %h expected a4", d); end
        bus_write(BASE + 16'd3, 8'h07);
        cs_begin();
        spi_byte(8'h81, r);
        cs_end();
        bus_read(BASE + 16'd4, d);
        vectors++;
        if (d !== 8'h01) begin errors++; $display("FAIL partial_next_count: got %h expected 01", d); end
        bus_read(BASE, d);
        vectors++;
        if (d !== 8'h81) begin errors++; $display("FAIL partial_next_byte: got %h expected 81", d); end
        bus_write(BASE + 16'd3, 8'h07);
    endtask

    task automatic test_irq();
        logic [7:0] d, r;
`ifdef SPI_SLAVE_6502_IRQ_EN
        bus_write(BASE + 16'd3, 8'h87);
        tick(2);
        vectors++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_idle: got %b expected 0", irq); end
        bus_read(BASE + 16'd3, d);
        vectors++;
        if (d !== 8'h80) begin errors++; $display("FAIL irq_ctrl_read: got %h expected 80", d); end
        cs_begin();
        spi_byte(8'h11, r);
        cs_end();
        vectors++;
        if (irq !== 1'b1) begin errors++; $display("FAIL irq_raised: got %b expected 1", irq); end
        bus_read(BASE, d);
        vectors++;
        if (d !== 8'h11) begin errors++; $display("FAIL irq_rx_pop: got %h expected 11", d); end
        tick(2);
        vectors++;
        if (irq !== 1'b1) begin errors++; $display("FAIL irq_held_by_frame_done: got %b expected 1", irq); end
        bus_write(BASE + 16'd3, 8'h04);
        vectors++;
        if (irq !== 1'b1) begin errors++; $display("FAIL irq_lag: got %b expected 1", irq); end
        @(posedge clk);
        #1;
        vectors++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_cleared: got %b expected 0", irq); end
`else
        bus_write(BASE + 16'd3, 8'h80);
        bus_read(BASE + 16'd3, d);
        vectors++;
        if (d !== 8'h00) begin errors++; $display("FAIL irq_ctrl_read: got %h expected 00", d); end
        cs_begin();
        spi_byte(8'h11, r);
        cs_end();
        vectors++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_tied_low: got %b expected 0", irq); end
        bus_read(BASE, d);
        vectors++;
        if (d !== 8'h11) begin errors++; $display("FAIL irq_rx_pop: got %h expected 11", d); end
`endif
        bus_write(BASE + 16'd3, 8'h07);
    endtask

    task automatic test_reset_midframe();
        logic [7:0] d, r;
        logic b;
        bus_write(BASE + 16'd1, 8'hC3);
        cs_begin();
        spi_bit(1'b1, b);
        vectors++;
        if (b !== 1'b1) begin errors++; $display("FAIL mid_first_bit: got %b expected 1", b); end
        tick(4);
        vectors++;
        if (miso !== 1'b1) begin errors++; $display("FAIL mid_second_bit: got %b expected 1", miso); end
        address = BASE + 16'd2;
        rd_wr = 1'b0;
        tick(1);
        vectors++;
        if (rdata !== 8'h44) begin errors++; $display("FAIL mid_status_live: got %h expected 44", rdata); end
        #2 reset = 1'b1;
        #1;
        vectors++;
        if ({rdata, miso, irq} !== 10'h000) begin
            errors++;
            $display("FAIL mid_async_reset: got data_o=%h miso=%b irq=%b expected 00/0/0", rdata, miso, irq);
        end
        address = 16'h0000;
        cs_n = 1'b1;
        mosi = 1'b0;
        tick(3);
        reset = 1'b0;
        tick(4);
        bus_read(BASE + 16'd2, d);
        vectors++;
        if (d !== 8'h04) begin errors++; $display("FAIL mid_status_after_reset: got %h expected 04", d); end
        bus_write(BASE + 16'd1, 8'h96);
        cs_begin();
        spi_byte(8'h69, r);
        cs_end();
        vectors++;
        if (r !== 8'h96) begin errors++; $display("FAIL mid_next_host_rx: got %h expected 96", r); end
        bus_read(BASE, d);
        vectors++;
        if (d !== 8'h69) begin errors++; $display("FAIL mid_next_rx_pop: got %h expected 69", d); end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_overflow();
        test_partial_frame();
        test_irq();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/spi_slave_6502.md
Name: spi_slave_6502

Overview:
- Memory-mapped SPI responder on the 6502 data bus; the target-side counterpart of the existing spi_master peripherals.
- Lets an external SPI host exchange byte streams with 6502 firmware (host bring-up link, board-to-board link).
- SPI mode 0, MSB first, byte-oriented, with RX and TX FIFOs.
- Sits on the bus like other peripherals: CPU address/data/rd_wr_i in; registered data_o into the top-level read mux.

Parameters:
- BaseAddress, 'h9230, first register address; block decodes BaseAddress..BaseAddress+4.
- FifoDepth, 8, entries per FIFO; power of 2, minimum 2.
- FillByte, 'hFF, byte shifted out on MISO when TX FIFO is empty.
- address_width, 16, bus address width.
- data_width, 8, bus data width; must be 8.

Ports:
- clk_i  in  1  system clock.
- reset_i  in  1  asynchronous active-high reset.
- address_i  in  address_width  CPU address.
- data_i  in  data_width  CPU write data.
- data_o  out  data_width  registered read data.
- rd_wr_i  in  1  1=write, 0=read.
- spi_sclk_i  in  1  host SPI clock; async, max clk_i/8.
- spi_cs_ni  in  1  host chip select, active low; async.
- spi_mosi_i  in  1  host data in.
- spi_miso_o  out  1  data to host; driven 0 when CS inactive.
- irq_o  out  1  interrupt request, active high (see Optional Feature).

Behaviour:
- Reset (async, reset_i=1): data_o=0, spi_miso_o=0, irq_o=0, both FIFOs empty, all sticky flags 0, irq_en=0, bit counter 0, shift registers 0.
- Input sync: sclk, cs_n and mosi each pass through 2 flops. Edges are detected on the synced values. The SPI-to-bus latency (3 clk_i) is inherent.
- Register map (offset: read / write):
  - +0: RX pop / ignored.
  - +1: reads 0 / TX push.
  - +2: STATUS / ignored.
  - +3: CTRL / CTRL.
  - +4: RX count / ignored.
- STATUS bits: 0 rx_not_empty, 1 rx_full, 2 tx_empty, 3 tx_full, 4 rx_overflow (sticky), 5 tx_underflow (sticky), 6 cs_active (synced), 7 frame_done (sticky).
- CTRL write bits (write-1 actions):
  - 0 clr rx_overflow, 1 clr tx_underflow, 2 clr frame_done, 3 flush RX, 4 flush TX.
  - Bit 7 sets irq_en; irq_en is readable at bit 7, other read bits 0.
- Bus timing:
  - data_o is updated every clk_i.
  - If address_i is in range and rd_wr_i=0, data_o <= addressed value next cycle; otherwise data_o <= 0.
  - A read of +0 pops one entry in that same cycle. Reading +0 while RX is empty returns 0 with no pop.
  - A write of +1 while TX is full is dropped; no flag is set.
- Frame state machine:
  - IDLE: on synced CS fall -> ACTIVE. Load the TX shift register (TX FIFO head with pop, or FillByte with tx_underflow set if empty). bitcnt=0. MISO = bit 7.
  - ACTIVE, sclk rise: shift synced MOSI into the RX shifter and bitcnt++.
    - At bitcnt 7->0, push the assembled byte. If RX is full, drop it and set rx_overflow.
  - ACTIVE, sclk fall: if bitcnt!=0, shift TX left and MISO = next bit.
    - If bitcnt==0 (byte boundary), load the next TX byte per the IDLE load rule.
  - ACTIVE, on synced CS rise -> IDLE. Discard any partial RX byte, set frame_done, MISO=0.
  - CS rise takes priority over an sclk edge in the same cycle.
- Simultaneous events:
  - CPU pop plus SPI push in the same cycle are both performed; count unchanged. This holds even when full.
  - CPU push plus SPI pop on TX likewise.
  - Flush beats push or pop in the same cycle; the FIFO ends empty.
  - A clear beats a set of a sticky flag in the same cycle; the flag ends 0.
- Pointers are log2(FifoDepth) bits and wrap naturally. Counts are log2(FifoDepth)+1 bits.
- Reset mid-frame returns the block to IDLE immediately, with all state at reset values.

Optional Feature:
- Macro: SPI_SLAVE_6502_IRQ_EN.
- Defined: irq_o is registered. irq_o = irq_en & (rx_not_empty | rx_overflow | frame_done), updating 1 cycle after the cause.
- Undefined: irq_o is tied 0. CTRL bit 7 is not stored and reads 0.

Test Plan:
- Reset, then read +2 -> 'h04 (tx_empty only). Read +0 -> 0. spi_miso_o=0.
- Write 'hA5 to +1, then host frame (sclk=clk_i/8) sending 'h3C -> host receives 'hA5. Read +4 -> 1. Read +0 -> 'h3C. STATUS bit7=1.
- Host sends FifoDepth+1 bytes with TX empty -> host receives 'hFF each byte. STATUS shows rx_full, rx_overflow, tx_underflow. Write CTRL 'h1B -> STATUS reads 'h04 or 'h44 per CS state.
- CS rises after 5 bits -> RX count unchanged, frame_done=1. The next full frame byte 'h81 is received intact.
- With SPI_SLAVE_6502_IRQ_EN: write CTRL 'h80, host sends 'h11 -> irq_o=1. Pop +0 and clear frame_done -> irq_o=0 one cycle later. Without the macro, irq_o stays 0 throughout.
- Assert reset_i mid-byte -> all outputs 0 asynchronously. After release, the next frame works normally.
